// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first, registered carry loop.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_sr_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic fa_a;
    logic fa_b;
    logic fa_s;
    logic fa_co;

    // Single full-adder cell plus the sum-register shift that feeds the completion copy.
    always_comb begin
        fa_a        = a_sr[0];
        fa_b        = b_sr[0];
        fa_s        = fa_a ^ fa_b ^ carry;
        fa_co       = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));
        sum_sr_next = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        sum_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_sr_next;
                    carry  <= fa_co;
                    cnt    <= cnt + CNT_W'(1);
                    // Last bit: publish results; carry still holds the carry into the MSB.
                    if (cnt == LAST_BIT) begin
                        sum   <= sum_sr_next;
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ fa_co;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
